// File: rtl/fp_div_iter.sv
// Iterative IEEE-754 single-precision divider (FDIV.S): restoring mantissa
// division at one quotient bit per cycle, round-to-nearest-even, RISC-V fflags.
module fp_div_iter #(
  parameter int ITER = 26
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [4:0]  flags
);

  localparam logic [31:0] QNAN     = 32'h7FC0_0000;
  localparam logic [4:0]  LAST_CNT = 5'(ITER - 1);

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_DIV, S_ROUND} state_e;

  state_e            state_q, state_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [31:0]       result_q, result_d;
  logic [4:0]        flags_q, flags_d;
  logic [31:0]       a_q, a_d, b_q, b_d;
  logic [24:0]       rem_q, rem_d;
  logic [23:0]       mb_q, mb_d;
  logic [ITER-1:0]   quo_q, quo_d;
  logic signed [9:0] exp_q, exp_d;
  logic              sign_q, sign_d;
  logic [4:0]        cnt_q, cnt_d;

  // Operand classification; subnormals collapse onto signed zero.
  logic [7:0]        ea, eb;
  logic [22:0]       fa, fb;
  logic [23:0]       ma, mb;
  logic              a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero;
  logic              sign_ab, is_special;
  logic [31:0]       sp_result;
  logic [4:0]        sp_flags;
  logic signed [9:0] exp_n;

  always_comb begin
    ea      = a_q[30:23];
    eb      = b_q[30:23];
    fa      = a_q[22:0];
    fb      = b_q[22:0];
    ma      = {1'b1, fa};
    mb      = {1'b1, fb};
    a_nan   = (ea == 8'hFF) && (fa != 23'd0);
    b_nan   = (eb == 8'hFF) && (fb != 23'd0);
    a_snan  = a_nan && !fa[22];
    b_snan  = b_nan && !fb[22];
    a_inf   = (ea == 8'hFF) && (fa == 23'd0);
    b_inf   = (eb == 8'hFF) && (fb == 23'd0);
    a_zero  = (ea == 8'h00);
    b_zero  = (eb == 8'h00);
    sign_ab = a_q[31] ^ b_q[31];
    exp_n   = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd127;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    is_special = 1'b1;
    sp_result  = 32'd0;
    sp_flags   = 5'd0;
    if (a_nan || b_nan) begin
      sp_result   = QNAN;
      sp_flags[4] = a_snan || b_snan;
    end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
      sp_result   = QNAN;
      sp_flags[4] = 1'b1;
    end else if (a_inf) begin
      sp_result = {sign_ab, 8'hFF, 23'd0};
    end else if (b_zero) begin
      sp_result   = {sign_ab, 8'hFF, 23'd0};
      sp_flags[3] = 1'b1;
    end else if (b_inf || a_zero) begin
      sp_result = {sign_ab, 31'd0};
    end else begin
      is_special = 1'b0;
    end
  end

  // One restoring step: the remainder stays below 2*mb, so the difference fits 24 bits.
  logic        qbit;
  logic [24:0] diff;

  always_comb begin
    qbit = (rem_q >= {1'b0, mb_q});
    diff = qbit ? (rem_q - {1'b0, mb_q}) : rem_q;
  end

  logic [23:0]       mant;
  logic              g_bit, r_bit, sticky, round_up;
  logic [24:0]       mant_r;
  logic signed [9:0] exp_r;

  always_comb begin
    mant     = quo_q[ITER-1 -: 24];
    g_bit    = quo_q[1];
    r_bit    = quo_q[0];
    sticky   = |rem_q;
    round_up = g_bit & (r_bit | sticky | mant[0]);
    mant_r   = {1'b0, mant} + {24'd0, round_up};
    exp_r    = exp_q + (mant_r[24] ? 10'sd1 : 10'sd0);
  end

  always_ff @(posedge CLK) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_CHECK;
      S_CHECK: state_d = is_special ? S_IDLE : S_DIV;
      S_DIV:   if (cnt_q == LAST_CNT) state_d = S_ROUND;
      S_ROUND: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    flags_d  = flags_q;
    a_d      = a_q;
    b_d      = b_q;
    rem_d    = rem_q;
    mb_d     = mb_q;
    quo_d    = quo_q;
    exp_d    = exp_q;
    sign_d   = sign_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d    = a;
          b_d    = b;
          busy_d = 1'b1;
        end
      end
      S_CHECK: begin
        sign_d = sign_ab;
        if (is_special) begin
          result_d = sp_result;
          flags_d  = sp_flags;
          done_d   = 1'b1;
          busy_d   = 1'b0;
        end else begin
          mb_d  = mb;
          quo_d = '0;
          cnt_d = 5'd0;
          // Pre-normalise so the first quotient bit is always 1.
          if (ma < mb) begin
            rem_d = {ma, 1'b0};
            exp_d = exp_n - 10'sd1;
          end else begin
            rem_d = {1'b0, ma};
            exp_d = exp_n;
          end
        end
      end
      S_DIV: begin
        rem_d = {diff[23:0], 1'b0};
        quo_d = {quo_q[ITER-2:0], qbit};
        cnt_d = cnt_q + 5'd1;
      end
      S_ROUND: begin
        done_d = 1'b1;
        busy_d = 1'b0;
        if (exp_r >= 10'sd255) begin
          result_d = {sign_q, 8'hFF, 23'd0};
          flags_d  = 5'b00101;
        end else if (exp_r <= 10'sd0) begin
          result_d = {sign_q, 31'd0};
          flags_d  = 5'b00011;
        end else begin
          result_d = {sign_q, exp_r[7:0], mant_r[22:0]};
          flags_d  = {4'd0, g_bit | r_bit | sticky};
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= 32'd0;
      flags_q  <= 5'd0;
    end else begin
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  // NOTE: the datapath is left unreset; it is always reloaded in CHECK before it is read.
  always_ff @(posedge CLK) begin
    a_q    <= a_d;
    b_q    <= b_d;
    rem_q  <= rem_d;
    mb_q   <= mb_d;
    quo_q  <= quo_d;
    exp_q  <= exp_d;
    sign_q <= sign_d;
    cnt_q  <= cnt_d;
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign flags  = flags_q;

endmodule

// File: tb/tb_fp_div_iter.sv
// Scoreboard bench for fp_div_iter: directed test-plan vectors plus random
// operands checked against an exact integer-division reference model.
module tb_fp_div_iter;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        start_i = 1'b0;
  logic [31:0] a_i = 32'd0;
  logic [31:0] b_i = 32'd0;
  logic        busy_o, done_o;
  logic [31:0] result_o;
  logic [4:0]  flags_o;

  fp_div_iter #(.ITER(26)) dut (
    .CLK    (CLK),
    .RST    (RST),
    .start  (start_i),
    .a      (a_i),
    .b      (b_i),
    .busy   (busy_o),
    .done   (done_o),
    .result (result_o),
    .flags  (flags_o)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  flg;
    int          lat;
    longint      t0;
  } sb_entry_t;

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] res;
    logic [4:0]  flg;
    int          lat;
  } dir_t;

  sb_entry_t sb[$];
  int        n_checks = 0;
  int        n_fail   = 0;

  dir_t dirs[9] = '{
    '{32'h40C00000, 32'h40000000, 32'h40400000, 5'h00, 28},
    '{32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 5'h01, 28},
    '{32'h3F800000, 32'h00000000, 32'h7F800000, 5'h08, 1},
    '{32'h00000000, 32'h00000000, 32'h7FC00000, 5'h10, 1},
    '{32'h7F800000, 32'hFF800000, 32'h7FC00000, 5'h10, 1},
    '{32'h7F800001, 32'h3F800000, 32'h7FC00000, 5'h10, 1},
    '{32'hC0000000, 32'h7F800000, 32'h80000000, 5'h00, 1},
    '{32'h7F000000, 32'h3E800000, 32'h7F800000, 5'h05, 28},
    '{32'h00800000, 32'h40000000, 32'h00000000, 5'h03, 28}
  };

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // Exact quotient by wide integer division, then round-to-nearest-even.
  function automatic void ref_div(input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] r, output logic [4:0] f,
                                  output int lat);
    logic            s;
    int              ex, ey, e, sh;
    logic [22:0]     fx, fy;
    bit              xnan, ynan, xsnan, ysnan, xinf, yinf, xzero, yzero, up, inexact;
    longint unsigned mx, my, num, q, rm, low, half, mant;
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    fx = x[22:0];
    fy = y[22:0];
    s  = x[31] ^ y[31];
    xnan  = (ex == 255) && (fx != 0);
    ynan  = (ey == 255) && (fy != 0);
    xsnan = xnan && !fx[22];
    ysnan = ynan && !fy[22];
    xinf  = (ex == 255) && (fx == 0);
    yinf  = (ey == 255) && (fy == 0);
    xzero = (ex == 0);
    yzero = (ey == 0);
    lat = 1;
    f   = 5'h00;
    r   = 32'h0;
    if (xnan || ynan) begin
      r = 32'h7FC00000;
      f = (xsnan || ysnan) ? 5'h10 : 5'h00;
      return;
    end
    if ((xzero && yzero) || (xinf && yinf)) begin r = 32'h7FC00000; f = 5'h10; return; end
    if (xinf)                               begin r = {s, 8'hFF, 23'd0}; return; end
    if (yzero)                              begin r = {s, 8'hFF, 23'd0}; f = 5'h08; return; end
    if (yinf || xzero)                      begin r = {s, 31'd0}; return; end
    lat  = 28;
    mx   = 64'(longint'({1'b1, fx}));
    my   = 64'(longint'({1'b1, fy}));
    num  = mx << 40;
    q    = num / my;
    rm   = num % my;
    e    = ex - ey + 127;
    if (q >= (64'd1 << 40)) sh = 17;
    else begin sh = 16; e = e - 1; end
    mant    = q >> sh;
    low     = q & ((64'd1 << sh) - 1);
    half    = 64'd1 << (sh - 1);
    inexact = (low != 0) || (rm != 0);
    up      = (low > half) || ((low == half) && ((rm != 0) || mant[0]));
    mant    = mant + (up ? 64'd1 : 64'd0);
    if (mant == (64'd1 << 24)) begin mant = 64'd1 << 23; e = e + 1; end
    if (e >= 255)    begin r = {s, 8'hFF, 23'd0}; f = 5'h05; end
    else if (e <= 0) begin r = {s, 31'd0};        f = 5'h03; end
    else begin
      r = {s, 8'(e), 23'(mant)};
      f = {4'd0, inexact};
    end
  endfunction

  function automatic logic [31:0] rand_fp();
    logic        s;
    logic [22:0] fr;
    int          k;
    s  = 1'($urandom);
    fr = 23'($urandom);
    k  = $urandom_range(0, 19);
    case (k)
      0:       return {s, 31'd0};
      1:       return {s, 8'hFF, 23'd0};
      2:       return {s, 8'hFF, fr | 23'd1};
      3:       return {s, 8'h00, fr};
      default: return {s, 8'($urandom_range(1, 254)), fr};
    endcase
  endfunction

  // Called at a negedge with the DUT able to accept; pushes on the accepting edge.
  task automatic issue(input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] er, input logic [4:0] ef, input int lat);
    sb_entry_t ent;
    start_i = 1'b1;
    a_i     = x;
    b_i     = y;
    @(posedge CLK);
    ent.res = er;
    ent.flg = ef;
    ent.lat = lat;
    ent.t0  = longint'($time);
    sb.push_back(ent);
    #1 start_i = 1'b0;
  endtask

  task automatic issue_model(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] er;
    logic [4:0]  ef;
    int          lat;
    ref_div(x, y, er, ef, lat);
    issue(x, y, er, ef, lat);
  endtask

  task automatic wait_idle(input int max_cycles);
    for (int i = 0; i < max_cycles && sb.size() > 0; i++) @(negedge CLK);
    if (sb.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_idle: %0d ops still pending after %0d cycles", sb.size(), max_cycles);
      sb.delete();
    end
    @(negedge CLK);
  endtask

  // Monitor: pops on every done, and tracks busy and result/flags hold between dones.
  sb_entry_t   mon_e;
  logic [31:0] hold_res = 32'd0;
  logic [4:0]  hold_flg = 5'd0;

  always @(negedge CLK) begin
    if (RST) begin
      hold_res = 32'd0;
      hold_flg = 5'd0;
    end else if (done_o) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL spurious_done: done=1 with no op outstanding (t=%0t)", $time);
      end else begin
        mon_e = sb.pop_front();
        check("result",  result_o, mon_e.res);
        check("flags",   32'(flags_o), 32'(mon_e.flg));
        check("latency", 32'(($time - 5 - mon_e.t0) / 10), 32'(mon_e.lat));
      end
      check("busy_at_done", 32'(busy_o), 32'd0);
      hold_res = result_o;
      hold_flg = flags_o;
    end else begin
      check("busy", 32'(busy_o), (sb.size() > 0) ? 32'd1 : 32'd0);
      check("result_hold", result_o, hold_res);
      check("flags_hold",  32'(flags_o), 32'(hold_flg));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst_busy",   32'(busy_o), 32'd0);
    check("rst_done",   32'(done_o), 32'd0);
    check("rst_result", result_o, 32'd0);
    check("rst_flags",  32'(flags_o), 32'd0);
    RST = 1'b0;
    @(negedge CLK);

    foreach (dirs[i]) begin
      issue(dirs[i].x, dirs[i].y, dirs[i].res, dirs[i].flg, dirs[i].lat);
      wait_idle(40);
    end

    // Starts during busy must be ignored.
    issue(32'h40C00000, 32'h40000000, 32'h40400000, 5'h00, 28);
    repeat (3) @(negedge CLK);
    start_i = 1'b1; a_i = 32'h3F800000; b_i = 32'h40400000;
    @(negedge CLK);
    start_i = 1'b0;
    repeat (11) @(negedge CLK);
    start_i = 1'b1; a_i = 32'h00000000; b_i = 32'h00000000;
    @(negedge CLK);
    start_i = 1'b0;
    wait_idle(40);

    // Back-to-back: new start in the done cycle.
    issue(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 5'h01, 28);
    begin
      int n = 0;
      do begin @(negedge CLK); n++; end while (!done_o && n < 40);
      if (!done_o) begin
        n_checks++;
        n_fail++;
        $display("FAIL b2b_wait: no done within 40 cycles");
      end
    end
    issue(32'h40C00000, 32'h40000000, 32'h40400000, 5'h00, 28);
    wait_idle(40);

    // Reset in the middle of an operation.
    issue(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 5'h01, 28);
    repeat (10) @(negedge CLK);
    RST = 1'b1;
    sb.delete();
    @(posedge CLK);
    @(negedge CLK);
    check("midrst_busy",   32'(busy_o), 32'd0);
    check("midrst_done",   32'(done_o), 32'd0);
    check("midrst_result", result_o, 32'd0);
    check("midrst_flags",  32'(flags_o), 32'd0);
    RST = 1'b0;
    repeat (40) @(negedge CLK);
    issue(32'h40C00000, 32'h40000000, 32'h40400000, 5'h00, 28);
    wait_idle(40);

    // Random operands, including specials, subnormals and range limits.
    for (int i = 0; i < 150; i++) begin
      issue_model(rand_fp(), rand_fp());
      wait_idle(40);
    end

    repeat (5) @(negedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_div_iter.md
Name: fp_div_iter

Overview:
- Multi-cycle IEEE-754 single-precision divider for the F-extension datapath (FDIV.S).
- Its registered result drives the FP write-back selector's third data input.
- The core stalls on `busy`.
- Iterative restoring mantissa division, one quotient bit per cycle, round-to-nearest-even only, RISC-V fflags output.

Parameters:
- ITER, 26, quotient bits produced: 24 significand bits + guard + round.

Ports:
- CLK  in  1  clock, rising-edge.
- RST  in  1  synchronous active-high reset.
- start  in  1  one-cycle request; sampled only when `busy`=0.
- a  in  32  dividend, FP32.
- b  in  32  divisor, FP32.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse; `result` and `flags` are valid.
- result  out  32  quotient, FP32; held until next `done`.
- flags  out  5  {NV,DZ,OF,UF,NX} in bits 4..0; held with `result`.

Behaviour:
- Reset: state=IDLE, busy=0, done=0, result=32'h0, flags=5'h0. RST mid-operation abandons the op; no `done` follows.
- States: IDLE -> CHECK -> DIV -> ROUND -> IDLE.
  - CHECK may go directly to IDLE with `done` for special operands.
- start accepted at edge k (state IDLE, start=1):
  - latch a, b; busy=1 from edge k.
  - start while busy=1 is ignored.
  - start during the `done` cycle is accepted (back-to-back).
- CHECK (edge k+1): unpack sign/exp/mantissa; subnormal inputs are treated as signed zero. Specials, with sign = sa^sb unless NaN:
  - any NaN, 0/0, inf/inf -> 32'h7FC00000; NV=1 if 0/0, inf/inf, or either input is sNaN.
  - finite nonzero / 0 -> ±inf, DZ=1.
  - inf / finite -> ±inf, no flags.
  - finite / inf, or 0 / nonzero finite -> ±0, no flags.
  - For a special: result, flags, done=1 and busy=0 take effect at edge k+1; done high for one cycle.
- Normal path, set up in CHECK:
  - ma, mb = 24-bit with hidden 1.
  - exp = ea - eb + 127, signed 10-bit.
  - if ma < mb: rem = ma<<1 and exp -= 1; else rem = ma.
- DIV (edges k+2..k+27, ITER cycles):
  - each cycle: qbit = (rem >= mb); rem = (rem - qbit·mb) << 1; shift qbit into q (MSB first).
  - 5-bit counter terminates after exactly ITER iterations.
  - q[25]=1 always; sticky = (rem != 0).
- ROUND (edge k+28):
  - mant = q[25:2], G = q[1], R = q[0].
  - round up iff G & (R | sticky | mant[0]).
  - round carry out of 24 bits: mant = 1.0, exp += 1.
  - exp >= 255 -> ±inf, OF=1, NX=1.
  - exp <= 0 -> ±0 (flush, no subnormal output), UF=1, NX=1.
  - otherwise NX = G|R|sticky.
  - result, flags and done=1 take effect at edge k+28; busy=0 at the same edge.
- Latency, start-sample edge to done edge: normal 28 edges; special 1 edge.
- `done` is never asserted in two consecutive cycles unless a new start was accepted.
- `result` and `flags` do not change except on a done edge or reset.

Test Plan:
1. a=0x40C00000 (6.0), b=0x40000000 (2.0) -> result 0x40400000, flags 0x00; done exactly 28 edges after start; busy high throughout.
2. a=0x3F800000 (1.0), b=0x40400000 (3.0) -> result 0x3EAAAAAB, flags 0x01 (NX).
3. Specials, each with done 1 edge after start:
   - 1.0/0x00000000 -> 0x7F800000, flags 0x08.
   - 0/0 -> 0x7FC00000, flags 0x10.
   - 0x7F800000/0xFF800000 -> 0x7FC00000, flags 0x10.
   - 0x7F800001 (sNaN)/1.0 -> 0x7FC00000, flags 0x10.
   - -2.0/0x7F800000 -> 0x80000000, flags 0x00.
4. Range limits:
   - 0x7F000000/0x3E800000 -> 0x7F800000, flags 0x05.
   - 0x00800000/0x40000000 -> 0x00000000, flags 0x03.
5. Handshake:
   - pulse start again at cycles 3 and 15 of an op -> ignored; single done; result matches the first operands.
   - new start in the done cycle -> accepted; second done 28 edges later.
6. Reset: assert RST at cycle 10 of a normal op -> busy=0, done=0, result=0, flags=0 next edge; no done pulse afterwards; a following op completes correctly.
